// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-7-segment decoder for the debug display.
package seg_pkg;
    localparam int         NDIG    = 8;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low segment pattern, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction
endpackage

// File: rtl/seg_display_ctrl_if.sv
// Board-facing signal bundle of the debug display: button, debug words, display drive.
// Handshake: none; words are sampled levels, SEG/AN/sel are registered and valid every cycle.
interface seg_display_ctrl_if;
    logic        btn0;
    logic [31:0] word0;
    logic [31:0] word1;
    logic [31:0] word2;
    logic [31:0] word3;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic [1:0]  sel;
    logic        dbg_level;

    modport master (
        output btn0, word0, word1, word2, word3,
        input  SEG, AN, sel, dbg_level
    );

    modport slave (
        input  btn0, word0, word1, word2, word3,
        output SEG, AN, sel, dbg_level
    );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level debouncer and a one-cycle press pulse.
module btn_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic press
);
    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // The level flips only after DEB_CYC consecutive disagreeing samples;
    // a single agreeing sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEB_CYC - 1)) begin
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_press;
endmodule

// File: rtl/seg_display_ctrl.sv
// 8-digit hex debug display: button-stepped word selector, per-frame snapshot and
// time-multiplexed digit scanner with blanking at the start of every digit slot.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_WORDS = 4,
    parameter int SCAN_BITS = 17,
    parameter int BLANK_CYC = 16,
    parameter int DEB_CYC   = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    seg_display_ctrl_if.slave bus
);
    localparam int         OFS_BITS = SCAN_BITS - 3;
    localparam logic [1:0] LAST_SEL = 2'(NUM_WORDS - 1);

    logic                 w_level;
    logic                 w_press;
    logic [1:0]           r_sel;
    logic [SCAN_BITS-1:0] r_scan;
    logic [31:0]          r_snap;
    logic [31:0]          w_word;
    logic [31:0]          w_frame;
    logic [2:0]           w_digit;
    logic [OFS_BITS-1:0]  w_ofs;
    logic [3:0]           w_nib;
    logic                 w_blank;
    logic [NDIG-1:0]      r_an;
    logic [7:0]           r_seg;
    logic [NDIG-1:0]      w_an_next;
    logic [7:0]           w_seg_next;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (bus.btn0),
        .level (w_level),
        .press (w_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel <= 2'd0;
        end else if (w_press) begin
            r_sel <= (r_sel == LAST_SEL) ? 2'd0 : r_sel + 2'd1;
        end
    end

    // Indices beyond NUM_WORDS are never reached by r_sel; they fold onto word0.
    always_comb begin
        w_word = bus.word0;
        case (r_sel)
            2'd0:    w_word = bus.word0;
            2'd1:    w_word = bus.word1;
            2'd2:    w_word = (NUM_WORDS > 2) ? bus.word2 : bus.word0;
            default: w_word = (NUM_WORDS > 3) ? bus.word3 : bus.word0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan <= '0;
            r_snap <= '0;
        end else begin
            r_scan <= r_scan + SCAN_BITS'(1);
            if (r_scan == '0) begin
                r_snap <= w_word;
            end
        end
    end

    // At scan==0 the snapshot is being loaded, so the decoder sees the incoming word.
    always_comb begin
        w_digit    = r_scan[SCAN_BITS-1 -: 3];
        w_ofs      = r_scan[OFS_BITS-1:0];
        w_frame    = (r_scan == '0) ? w_word : r_snap;
        w_nib      = w_frame[{w_digit, 2'b00} +: 4];
        w_blank    = (32'(w_ofs) < 32'(BLANK_CYC));
        w_an_next  = AN_OFF;
        w_seg_next = SEG_OFF;
        if (!w_blank) begin
            w_an_next  = ~(NDIG'(1) << w_digit);
            w_seg_next = {({1'b0, r_sel} == w_digit) ? 1'b0 : 1'b1, hex7(w_nib)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign bus.AN        = r_an;
    assign bus.SEG       = r_seg;
    assign bus.sel       = r_sel;
    assign bus.dbg_level = w_level;
endmodule
